// File: rtl/core2axi_mo_pkg.sv
// rtl/core2axi_mo_pkg.sv - shared types, AXI constants and helpers for core2axi_mo
package core2axi_mo_pkg;

    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_type_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic [2:0] axi_size(input int data_width);
        int         bytes;
        logic [2:0] size;
        bytes = data_width / 8;
        size  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/core2axi_mo_order_fifo.sv
// rtl/core2axi_mo_order_fifo.sv - issue-order FIFO, push and pop may coincide even when full
module core2axi_mo_order_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/core2axi_mo.sv
// rtl/core2axi_mo.sv - OBI core port to AXI4 single-beat bridge, multiple outstanding, in-order responses
// Optional error reporting on err_o: CORE2AXI_MO_ERR_RESP_EN
module core2axi_mo
    import core2axi_mo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [ID_WIDTH-1:0]     aw_id_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [1:0]              aw_burst_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [1:0]              b_resp_i,
    input  logic [ID_WIDTH-1:0]     b_id_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [ID_WIDTH-1:0]     ar_id_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic [ID_WIDTH-1:0]     r_id_i,
    input  logic                    r_last_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                  ar_pend;
    logic                  aw_pend;
    logic                  w_pend;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     be_q;

    logic                  hold_free;
    logic                  r_hs;
    logic                  b_hs;
    logic                  retire;
    txn_type_e             push_type;
    logic [0:0]            head;
    txn_type_e             head_type;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    core2axi_mo_order_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1),
        .CNT_W (CNT_W)
    ) u_order_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (gnt_o),
        .push_data (push_type),
        .pop       (retire),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign push_type = we_i ? TXN_WRITE : TXN_READ;
    assign head_type = txn_type_e'(head);

    // Only the oldest transaction's channel is opened, which enforces issue order on responses.
    assign r_ready_o = !fifo_empty && (head_type == TXN_READ);
    assign b_ready_o = !fifo_empty && (head_type == TXN_WRITE);
    assign r_hs      = r_valid_i & r_ready_o;
    assign b_hs      = b_valid_i & b_ready_o;
    assign retire    = r_hs | b_hs;

    // A retire frees a slot in the same cycle, so a full bridge can still grant.
    assign hold_free = !(ar_pend | aw_pend | w_pend);
    assign gnt_o     = req_i & hold_free & ((fifo_count < MAX_CNT) | retire);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ar_pend  <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            if (gnt_o) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
                ar_pend <= !we_i;
                aw_pend <= we_i;
                w_pend  <= we_i;
            end else begin
                if (ar_pend && ar_ready_i) ar_pend <= 1'b0;
                if (aw_pend && aw_ready_i) aw_pend <= 1'b0;
                if (w_pend && w_ready_i)   w_pend  <= 1'b0;
            end
            rvalid_o <= retire;
            if (r_hs) begin
                rdata_o <= r_data_i;
            end
        end
    end

`ifdef CORE2AXI_MO_ERR_RESP_EN
    logic err_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= r_hs ? r_resp_i[1] : (b_hs & b_resp_i[1]);
        end
    end
    assign err_o = err_q;

    logic unused_sig;
    assign unused_sig = ^{b_resp_i[0], r_resp_i[0], b_id_i, r_id_i, r_last_i, fifo_full};
`else
    assign err_o = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{b_resp_i, r_resp_i, b_id_i, r_id_i, r_last_i, fifo_full};
`endif

    assign ar_valid_o = ar_pend;
    assign ar_addr_o  = addr_q;
    assign ar_id_o    = ID_WIDTH'(AXI_ID);
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = axi_size(DATA_WIDTH);
    assign ar_burst_o = AXI_BURST_INCR;

    assign aw_valid_o = aw_pend;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = ID_WIDTH'(AXI_ID);
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = axi_size(DATA_WIDTH);
    assign aw_burst_o = AXI_BURST_INCR;

    assign w_valid_o  = w_pend;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = be_q;
    assign w_last_o   = 1'b1;

    stray_resp_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_empty |-> !(b_valid_i || r_valid_i));

endmodule
